// File: rtl/data_loader_ctrl.sv
// data_loader_ctrl: walks the x/y sample memories once per start, capturing each
// x[i]/y[i] pair after the memory read latency and presenting it downstream over a
// valid/ready handshake. Every output is a register.
// Build option: define DLC_EPOCH_EN to repeat the pass N_EPOCHS times per start
// and expose the current pass number on the epoch port.
module data_loader_ctrl #(
    parameter int N_SAMPLES = 150,
    parameter int DATA_W    = 20,
    parameter int ADDR_W    = 8,
    parameter int MEM_LAT   = 1,
    parameter int N_EPOCHS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_x,
    input  logic [DATA_W-1:0] mem_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef DLC_EPOCH_EN
    ,
    output logic [ADDR_W-1:0] epoch
`endif
);

    localparam int                CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(MEM_LAT - 1);
`ifdef DLC_EPOCH_EN
    localparam logic [ADDR_W-1:0] LAST_EPOCH = ADDR_W'(N_EPOCHS - 1);
`endif

    // Reject configurations the index/latency counters cannot represent.
    if (N_SAMPLES < 1 || N_SAMPLES > (1 << ADDR_W) || MEM_LAT < 1 || N_EPOCHS < 1) begin : g_param_check
        $error("data_loader_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_nxt;
    logic              rd_nxt, valid_nxt, last_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] x_nxt, y_nxt;
`ifdef DLC_EPOCH_EN
    logic [ADDR_W-1:0] epoch_nxt;
`endif

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_nxt = state;
        idx_nxt   = idx;
        wait_nxt  = wait_cnt;
        valid_nxt = out_valid;
        last_nxt  = out_last;
        x_nxt     = out_x;
        y_nxt     = out_y;
`ifdef DLC_EPOCH_EN
        epoch_nxt = epoch;
`endif
        if (abort) begin
            state_nxt = S_IDLE;
            valid_nxt = 1'b0;
            idx_nxt   = '0;
`ifdef DLC_EPOCH_EN
            epoch_nxt = '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_RD;
                        idx_nxt   = '0;
`ifdef DLC_EPOCH_EN
                        epoch_nxt = '0;
`endif
                    end
                end
                S_RD: begin
                    state_nxt = S_WAIT;
                    wait_nxt  = '0;
                end
                S_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state_nxt = S_PRESENT;
                        x_nxt     = mem_x;
                        y_nxt     = mem_y;
                        valid_nxt = 1'b1;
`ifdef DLC_EPOCH_EN
                        last_nxt  = (idx == LAST_IDX) && (epoch == LAST_EPOCH);
`else
                        last_nxt  = (idx == LAST_IDX);
`endif
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        valid_nxt = 1'b0;
                        if (idx != LAST_IDX) begin
                            state_nxt = S_RD;
                            idx_nxt   = idx + 1'b1;
`ifdef DLC_EPOCH_EN
                        end else if (epoch != LAST_EPOCH) begin
                            state_nxt = S_RD;
                            idx_nxt   = '0;
                            epoch_nxt = epoch + 1'b1;
`endif
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
        // Strobes and status follow directly from the state being entered.
        rd_nxt   = (state_nxt == S_RD);
        addr_nxt = rd_nxt ? idx_nxt : mem_addr;
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

    // State and output registers, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DLC_EPOCH_EN
            epoch     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            idx       <= idx_nxt;
            wait_cnt  <= wait_nxt;
            mem_rd_en <= rd_nxt;
            mem_addr  <= addr_nxt;
            out_valid <= valid_nxt;
            out_x     <= x_nxt;
            out_y     <= y_nxt;
            out_last  <= last_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
`ifdef DLC_EPOCH_EN
            epoch     <= epoch_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_data_loader_ctrl.sv
// tb_data_loader_ctrl: directed stimulus with a scoreboard; expected samples are
// queued when a run is started and a monitor pops them at each handshake.
module tb_data_loader_ctrl;

    localparam int N  = 150;
    localparam int DW = 20;
    localparam int AW = 8;
`ifdef DLC_EPOCH_EN
    localparam int NEP = 2;
`else
    localparam int NEP = 1;
`endif

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          last;
        logic [AW-1:0] ep;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, abort, out_ready;
    logic          mem_rd_en, out_valid, out_last, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_x, mem_y, out_x, out_y;
`ifdef DLC_EPOCH_EN
    logic [AW-1:0] epoch;
`endif

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_hs = -1;
    bit   spacing_chk = 1'b0;
    bit   pending_done = 1'b0;

    data_loader_ctrl #(
        .N_SAMPLES(N),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MEM_LAT  (1),
        .N_EPOCHS (NEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_x    (mem_x),
        .mem_y    (mem_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
`ifdef DLC_EPOCH_EN
        ,
        .epoch    (epoch)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to measure handshake spacing.
    always @(posedge clk) cyc++;

    // Sample memories with one cycle of read latency: x[i]=i, y[i]=i+1000.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_x <= DW'(mem_addr);
            mem_y <= DW'(mem_addr) + 20'd1000;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and tracks done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (pending_done) begin
            check("done_after_last", done, 1'b1);
            pending_done = 1'b0;
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: actual x=%0d required no sample", out_x);
            end else begin
                e = exp_q.pop_front();
                check("sb_x", out_x, e.x);
                check("sb_y", out_y, e.y);
                check("sb_last", out_last, e.last);
`ifdef DLC_EPOCH_EN
                check("sb_epoch", epoch, e.ep);
`endif
                if (spacing_chk && last_hs >= 0) check("sb_spacing", 64'(cyc - last_hs), 64'd3);
                last_hs = cyc;
                if (e.last) pending_done = 1'b1;
            end
        end
        if (done) done_cnt++;
    end

    task automatic push_run();
        for (int ep = 0; ep < NEP; ep++) begin
            for (int i = 0; i < N; i++) begin
                exp_q.push_back('{x: DW'(i), y: DW'(i + 1000),
                                  last: (i == N - 1) && (ep == NEP - 1), ep: AW'(ep)});
            end
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Wait for the scoreboard to empty and the DUT to return to idle.
    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", (n < max_cyc), 1'b1);
    endtask

    // Wait until the read strobe for a given address is seen.
    task automatic wait_rd(input logic [AW-1:0] addr, input int max_cyc);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < max_cyc) begin
            @(negedge clk);
            n++;
            found = (mem_rd_en === 1'b1) && (mem_addr === addr);
        end
        check("rd_seen", found, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_rd_en"}, mem_rd_en, 1'b0);
        check({tag, "_mem_addr"},  mem_addr,  '0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_x"},     out_x,     '0);
        check({tag, "_out_y"},     out_y,     '0);
        check({tag, "_out_last"},  out_last,  1'b0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_done"},      done,      1'b0);
`ifdef DLC_EPOCH_EN
        check({tag, "_epoch"},     epoch,     '0);
`endif
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        mem_x = '0; mem_y = '0;
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: asynchronous reset in the middle of a pass
        push_run();
        start_pulse();
        repeat (20) @(negedge clk);
        check("mid_pass_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        exp_q.delete();
        pending_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_busy", busy, 1'b0);

        // 2: full run with out_ready high, 3-cycle handshake spacing
        done_cnt = 0;
        last_hs = -1;
        spacing_chk = 1'b1;
        push_run();
        start_pulse();
        @(negedge clk);
        check("first_rd_en", mem_rd_en, 1'b1);
        check("first_addr", mem_addr, 8'd0);
        wait_drain(3 * N * NEP + 20);
        spacing_chk = 1'b0;
        check("run_done_count", done_cnt, 1);

        // 3: stall on x=10 for 5 cycles
        done_cnt = 0;
        push_run();
        start_pulse();
        wait_rd(8'd10, 100);
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_x", out_x, 20'd10);
            check("stall_y", out_y, 20'd1010);
            check("stall_last", out_last, 1'b0);
            check("stall_no_rd", mem_rd_en, 1'b0);
            check("stall_addr", mem_addr, 8'd10);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_no_rd", mem_rd_en, 1'b0);
        @(negedge clk);
        check("after_hs_rd", mem_rd_en, 1'b1);
        check("after_hs_addr", mem_addr, 8'd11);
        wait_drain(3 * N * NEP + 20);
        check("stall_done_count", done_cnt, 1);

        // 4: abort while sample 50 is valid, then restart from 0
        done_cnt = 0;
        push_run();
        start_pulse();
        wait_rd(8'd50, 300);
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_abort_valid", out_valid, 1'b1);
        check("pre_abort_x", out_x, 20'd50);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
`ifdef DLC_EPOCH_EN
        check("abort_epoch", epoch, '0);
`endif
        exp_q.delete();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle_busy", busy, 1'b0);
        check("abort_no_done", done_cnt, 0);
        push_run();
        start_pulse();
        wait_drain(3 * N * NEP + 20);
        check("restart_done_count", done_cnt, 1);

        // 5: start during a pass is ignored; start with abort in idle stays idle
        done_cnt = 0;
        push_run();
        start_pulse();
        repeat (30) @(negedge clk);
        start_pulse();
        wait_drain(3 * N * NEP + 20);
        check("restart_ignored_done", done_cnt, 1);
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", busy, 1'b0);
        check("start_abort_rd", mem_rd_en, 1'b0);
        repeat (3) @(negedge clk);
        check("start_abort_still_idle", busy, 1'b0);
        check("start_abort_no_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
